// File: rtl/multi_axis_step_gen.sv
// Purpose: per-axis STEP/DIR pulse generator with direction setup, minimum pulse widths and a signed position counter.
// Latency: step_out rises on the accepting edge (same direction) or DIR_SETUP edges later (direction change).
// Backpressure: step_ready low while an axis is busy or enable is low; a request refused while enabled sets the sticky missed flag.
module multi_axis_step_gen #(
  parameter int NUM_AXES  = 3,
  parameter int POS_W     = 32,
  parameter int STEP_HIGH = 4,
  parameter int STEP_LOW  = 4,
  parameter int DIR_SETUP = 2,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_AXES-1:0]       step_req,
  input  logic [NUM_AXES-1:0]       step_dir,
  output logic [NUM_AXES-1:0]       step_ready,
  input  logic [NUM_AXES-1:0]       pos_load,
  input  logic [NUM_AXES*POS_W-1:0] pos_load_val,
  input  logic [NUM_AXES-1:0]       missed_clr,
  output logic [NUM_AXES-1:0]       step_out,
  output logic [NUM_AXES-1:0]       dir_out,
  output logic [NUM_AXES*POS_W-1:0] position,
  output logic [NUM_AXES-1:0]       missed
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  // Counters run down to zero, so each phase loads (cycles - 1).
  // The idle cycle in which the next request is accepted already counts
  // as one low cycle, hence LOW only needs STEP_LOW-1 cycles of its own.
  localparam int HIGH_LOAD_I  = (STEP_HIGH > 1) ? STEP_HIGH - 1 : 0;
  localparam int LOW_LOAD_I   = (STEP_LOW > 2)  ? STEP_LOW - 2  : 0;
  localparam int SETUP_LOAD_I = (DIR_SETUP > 1) ? DIR_SETUP - 1 : 0;

  localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(HIGH_LOAD_I);
  localparam logic [CNT_W-1:0] LOW_LOAD   = CNT_W'(LOW_LOAD_I);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_LOAD_I);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

  localparam bit USE_LOW   = (STEP_LOW > 1);
  localparam bit USE_SETUP = (DIR_SETUP > 0);

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             step_q;
    logic             dir_q;
    logic             missed_q;
    logic [POS_W-1:0] pos_q;
    logic             accept;
    logic             dir_change;
    logic             fire;
    logic             move_dir;
    logic [POS_W-1:0] pos_step;

    assign step_ready[i] = (state == ST_IDLE) & enable;
    assign accept        = step_req[i] & step_ready[i];
    assign dir_change    = step_dir[i] != dir_q;

    // fire marks the edge where step_out rises and the position moves
    always_comb begin
      fire     = 1'b0;
      move_dir = dir_q;
      if (accept) begin
        fire     = !dir_change || !USE_SETUP;
        move_dir = step_dir[i];
      end else if (state == ST_SETUP && cnt == '0) begin
        fire = 1'b1;
      end
      pos_step = move_dir ? pos_q + POS_ONE : pos_q - POS_ONE;
    end

    // Pulse FSM: IDLE -> [SETUP] -> HIGH -> [LOW] -> IDLE
    always_ff @(posedge clk) begin
      if (!reset) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        step_q <= 1'b0;
        dir_q  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              dir_q <= step_dir[i];
              if (fire) begin
                state  <= ST_HIGH;
                cnt    <= HIGH_LOAD;
                step_q <= 1'b1;
              end else begin
                state <= ST_SETUP;
                cnt   <= SETUP_LOAD;
              end
            end
          end
          ST_SETUP: begin
            if (cnt == '0) begin
              state  <= ST_HIGH;
              cnt    <= HIGH_LOAD;
              step_q <= 1'b1;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (cnt == '0) begin
              step_q <= 1'b0;
              if (USE_LOW) begin
                state <= ST_LOW;
                cnt   <= LOW_LOAD;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          ST_LOW: begin
            if (cnt == '0) begin
              state <= ST_IDLE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            state  <= ST_IDLE;
            step_q <= 1'b0;
          end
        endcase
      end
    end

    // Position counter: a load beats a coincident step increment
    always_ff @(posedge clk) begin
      if (!reset) begin
        pos_q <= '0;
      end else if (pos_load[i]) begin
        pos_q <= pos_load_val[i*POS_W +: POS_W];
      end else if (fire) begin
        pos_q <= pos_step;
      end
    end

    // Sticky missed flag: a new miss beats a coincident clear
    always_ff @(posedge clk) begin
      if (!reset) begin
        missed_q <= 1'b0;
      end else if (step_req[i] && !step_ready[i] && enable) begin
        missed_q <= 1'b1;
      end else if (missed_clr[i]) begin
        missed_q <= 1'b0;
      end
    end

    assign step_out[i]                  = step_q;
    assign dir_out[i]                   = dir_q;
    assign missed[i]                    = missed_q;
    assign position[i*POS_W +: POS_W]   = pos_q;
  end

endmodule

// File: tb/tb_multi_axis_step_gen.sv
// Directed bench for multi_axis_step_gen: 3 axes, 16-bit positions, 4/4 pulse widths, 2-cycle direction setup.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Cycle index c counts edges after the accepting edge (c=0 is the accepting edge itself).
module tb_multi_axis_step_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  step_req;
  logic [2:0]  step_dir;
  logic [2:0]  step_ready;
  logic [2:0]  pos_load;
  logic [47:0] pos_load_val;
  logic [2:0]  missed_clr;
  logic [2:0]  step_out;
  logic [2:0]  dir_out;
  logic [47:0] position;
  logic [2:0]  missed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_axis_step_gen #(
    .NUM_AXES(3), .POS_W(16), .STEP_HIGH(4), .STEP_LOW(4), .DIR_SETUP(2), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .step_req(step_req), .step_dir(step_dir), .step_ready(step_ready),
    .pos_load(pos_load), .pos_load_val(pos_load_val), .missed_clr(missed_clr),
    .step_out(step_out), .dir_out(dir_out), .position(position), .missed(missed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pos_of(input int a);
    return position[a*16 +: 16];
  endfunction

  int rises, first_k, second_k;
  logic prev;

  initial begin
    reset = 1'b0; enable = 1'b0; step_req = '0; step_dir = '0;
    pos_load = '0; pos_load_val = '0; missed_clr = '0;
    repeat (3) tick();
    check("rst_step", step_out, 0);
    check("rst_dir", dir_out, 0);
    check("rst_pos", position[31:0], 0);
    check("rst_pos2", position[47:32], 0);
    check("rst_missed", missed, 0);
    check("rst_rdy_dis", step_ready, 0);
    reset = 1'b1; enable = 1'b1;
    #1;
    check("rdy_en", step_ready, 3'b111);

    // axis0 same direction, axis1 direction change, same accepting edge
    step_dir = 3'b010; step_req = 3'b011;
    tick();
    step_req = '0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      check("ax0_step", step_out[0], (c <= 3));
      check("ax0_rdy", step_ready[0], (c >= 7));
      check("ax1_dir", dir_out[1], 1);
      check("ax1_step", step_out[1], (c >= 2 && c <= 5));
      check("ax1_rdy", step_ready[1], (c >= 9));
      check("ax1_pos", pos_of(1), (c >= 2) ? 1 : 0);
    end
    check("ax0_pos", pos_of(0), 16'hFFFF);
    check("ax0_dir", dir_out[0], 0);

    // axis2 request held for 20 edges
    step_dir = 3'b000; step_req = 3'b100;
    rises = 0; first_k = -1; second_k = -1; prev = step_out[2];
    for (int k = 0; k < 20; k++) begin
      tick();
      if (step_out[2] && !prev) begin
        rises++;
        if (rises == 1) first_k = k;
        else if (rises == 2) second_k = k;
      end
      prev = step_out[2];
    end
    check("ax2_pulses", rises, 3);
    check("ax2_first", first_k, 0);
    check("ax2_spacing", second_k - first_k, 8);
    check("ax2_missed", missed, 3'b100);
    missed_clr = 3'b100;
    tick();
    check("missed_set_wins", missed, 3'b100);
    step_req = '0;
    tick();
    check("missed_cleared", missed, 3'b000);
    missed_clr = '0;
    check("ax2_pos", pos_of(2), 16'hFFFD);
    repeat (6) tick();
    check("ax2_rdy", step_ready[2], 1);

    // load 0x7FFF then a positive step with direction change: wraps to 0x8000
    pos_load = 3'b001; pos_load_val = 48'h0000_0000_7FFF;
    tick();
    pos_load = '0;
    check("load_7fff", pos_of(0), 16'h7FFF);
    step_dir = 3'b001; step_req = 3'b001;
    tick();
    step_req = '0;
    check("wrap_dir", dir_out[0], 1);
    check("wrap_setup_step", step_out[0], 0);
    tick();
    check("wrap_setup_pos", pos_of(0), 16'h7FFF);
    tick();
    check("wrap_pos", pos_of(0), 16'h8000);
    check("wrap_step", step_out[0], 1);
    repeat (7) tick();
    check("wrap_rdy", step_ready[0], 1);

    // load coincident with a step increment: load wins
    step_dir = 3'b001; step_req = 3'b001; pos_load = 3'b001; pos_load_val = 48'h0000_0000_0100;
    tick();
    step_req = '0; pos_load = '0;
    check("ld_vs_step_pos", pos_of(0), 16'h0100);
    check("ld_vs_step_out", step_out[0], 1);
    tick();
    check("ld_vs_step_hold", pos_of(0), 16'h0100);
    repeat (8) tick();

    // enable dropped during HIGH of axis1, request kept asserted
    step_dir = 3'b010; step_req = 3'b010;
    tick();
    enable = 1'b0;
    check("en_step_c0", step_out[1], 1);
    for (int c = 1; c < 10; c++) begin
      tick();
      check("en_step", step_out[1], (c <= 3));
      check("en_rdy", step_ready[1], 0);
      check("en_missed", missed[1], 0);
    end
    check("en_pos", pos_of(1), 16'h0002);
    step_req = '0; enable = 1'b1;
    #1;
    check("en_rdy_back", step_ready[1], 1);

    // reset asserted mid-HIGH
    step_dir = 3'b001; step_req = 3'b001;
    tick();
    step_req = '0;
    check("mid_step", step_out[0], 1);
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_step", step_out, 0);
    check("mid_rst_dir", dir_out, 0);
    check("mid_rst_pos", position[31:0], 0);
    check("mid_rst_rdy", step_ready, 3'b111);
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_axis_step_gen.md
Name: multi_axis_step_gen

Overview:
- Parametrised N-axis successor to motor_step_gen.
- Converts per-axis step requests from the profile generators into timed STEP/DIR pulses with:
  - guaranteed direction setup time,
  - minimum high and low pulse widths,
  - a signed position counter per axis.
- Sits between the acc_profile_gen/acc_step_gen pipeline and the motor driver pins inside top.
- Each axis has a ready/request handshake and a sticky missed-step flag.

Parameters:
- NUM_AXES, 3, number of independent axis channels
- POS_W, 32, width of each signed position counter
- STEP_HIGH, 4, step_out high time in clk cycles (>=1)
- STEP_LOW, 4, minimum step_out low time after a pulse, in clk cycles (>=1)
- DIR_SETUP, 2, cycles dir_out must be stable before step_out rises after a direction change (>=0)
- CNT_W, 8, width of the internal per-axis timing counter; must hold max(STEP_HIGH, STEP_LOW, DIR_SETUP)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low (0 = reset)
- enable  in  1  global step enable
- step_req  in  NUM_AXES  per-axis step request
- step_dir  in  NUM_AXES  requested direction, 1 = positive
- step_ready  out  NUM_AXES  axis can accept a request this cycle
- pos_load  in  NUM_AXES  per-axis position load strobe
- pos_load_val  in  NUM_AXES*POS_W  load values; axis i at bits [i*POS_W +: POS_W]
- missed_clr  in  NUM_AXES  clear sticky missed flag
- step_out  out  NUM_AXES  registered step pulse to driver
- dir_out  out  NUM_AXES  registered direction to driver
- position  out  NUM_AXES*POS_W  signed position per axis, same packing as pos_load_val
- missed  out  NUM_AXES  sticky: a request arrived while not ready

Behaviour:
- Reset: all state is sampled on the clk rising edge while reset==0. Outputs go to:
  - step_out=0, dir_out=0, position=0, missed=0
  - every axis FSM = IDLE
- Axes are fully independent; all rules below apply per axis i.
- Per-axis FSM states: IDLE, SETUP, HIGH, LOW.
- step_ready[i] = (state==IDLE) & enable. This is combinational from registered state.
- Accept: step_req & step_ready at edge k.
  - If step_dir == dir_out:
    - go to HIGH; step_out=1 from edge k+1.
    - position +=1 if dir_out else -=1, at edge k+1.
  - If step_dir != dir_out and DIR_SETUP>0:
    - dir_out = step_dir at edge k+1; go to SETUP for DIR_SETUP cycles.
    - step_out rises at edge k+1+DIR_SETUP; position updates at the same edge.
  - If step_dir != dir_out and DIR_SETUP==0:
    - dir_out and step_out change together at edge k+1.
- HIGH: step_out held 1 for exactly STEP_HIGH cycles, then 0; go to LOW.
- LOW: step_out 0 for STEP_LOW cycles, then IDLE.
  - Minimum accepted-request spacing with no direction change is STEP_HIGH+STEP_LOW cycles.
- dir_out only changes via an accepted request, so it is stable during HIGH and LOW (hold time guaranteed).
- Position arithmetic: two's complement, wraps modulo 2^POS_W with no saturation.
  - 0x7FFF_FFFF +1 -> 0x8000_0000.
- pos_load: loads pos_load_val at the next edge.
  - If the step increment falls in the same edge, the load wins and that increment is discarded.
- missed:
  - Set when step_req==1 and step_ready==0 while enable==1.
  - Cleared by missed_clr. Set wins over a simultaneous clear.
- enable low:
  - Requests are not accepted and missed is not set.
  - A pulse in progress (SETUP/HIGH/LOW) runs to completion.
- Reset mid-pulse: step_out drops at the reset edge with no completion of the pulse width. The driver-side glitch is accepted by design.
- Latency: request to step_out rising edge is 1 cycle (same direction) or 1+DIR_SETUP cycles (direction change).

Test Plan:
- Parameters for all scenarios: NUM_AXES=3, POS_W=16, STEP_HIGH=4, STEP_LOW=4, DIR_SETUP=2.
- Reset then hold reset high: all outputs 0; step_ready=3'b111 once enable=1.
- Axis0 req, dir=0 (matches dir_out=0), at edge 10:
  - step_out[0] high edges 11-14, low from 15;
  - position0 = 0xFFFF at edge 11;
  - step_ready[0] returns high for acceptance at edge 18.
- Axis1 req dir=1 at edge 10:
  - dir_out[1]=1 at edge 11;
  - step_out[1] high edges 13-16;
  - position1 = 1.
- Axis2 req held high every cycle for 20 cycles:
  - exactly 3 pulses 8 cycles apart;
  - missed[2]=1;
  - missed_clr together with a new miss leaves missed=1;
  - missed_clr alone clears it.
- pos_load axis0 = 0x7FFF, then a dir=1 step: position0 = 0x8000.
  - pos_load of 0x0100 coincident with a step increment edge: position0 = 0x0100.
- enable dropped during HIGH of axis1: pulse completes at 4 cycles; step_ready stays 0; no missed set.
- reset asserted mid-HIGH: step_out=0 and FSM IDLE at the next edge.
